// File: rtl/instruction_sequencer.sv
// Program feeder for simple_processor: holds up to DEPTH instruction words and
// issues them one at a time over DIN/run, waiting for done between issues.
module instruction_sequencer #(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_50MHz,
    input  logic              reset,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [15:0]       load_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    input  logic              done,
    output logic [15:0]       DIN,
    output logic              run,
    output logic              busy,
    output logic              seq_done,
    output logic              error,
    output logic [ADDR_W-1:0] pc
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [TW-1:0]   TIMER_END = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FINISH,
        S_ERROR
    } state_t;

    state_t            state, state_n;
    logic [15:0]       mem [DEPTH];
    logic [ADDR_W:0]   len_q, len_n, len_sat;
    logic [ADDR_W-1:0] pc_n;
    logic [15:0]       din_n;
    logic [TW-1:0]     timer, timer_n;

    assign len_sat = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;

    // Writes land only while idle; memory contents survive reset.
    always_ff @(posedge clk_50MHz) begin
        if (load_we && !busy)
            mem[load_addr] <= load_data;
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        din_n   = DIN;
        len_n   = len_q;
        timer_n = timer;
        case (state)
            S_IDLE, S_ERROR: begin
                if (start) begin
                    if (prog_len != '0) begin
                        len_n   = len_sat;
                        pc_n    = '0;
                        din_n   = mem[0];
                        state_n = S_ISSUE;
                    end else begin
                        state_n = S_FINISH;
                    end
                end
            end
            S_ISSUE: begin
                timer_n = '0;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                timer_n = timer + TW'(1);
                // done takes priority over a timeout landing in the same cycle
                if (done) begin
                    if ({1'b0, pc} == len_q - (ADDR_W + 1)'(1)) begin
                        state_n = S_FINISH;
                    end else begin
                        pc_n    = pc + ADDR_W'(1);
                        din_n   = mem[pc + ADDR_W'(1)];
                        state_n = S_ISSUE;
                    end
                end else if (timer_n == TIMER_END) begin
                    state_n = S_ERROR;
                end
            end
            S_FINISH: state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so that each is a plain flop.
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            state    <= S_IDLE;
            DIN      <= '0;
            pc       <= '0;
            len_q    <= '0;
            timer    <= '0;
            run      <= 1'b0;
            busy     <= 1'b0;
            seq_done <= 1'b0;
            error    <= 1'b0;
        end else begin
            state    <= state_n;
            DIN      <= din_n;
            pc       <= pc_n;
            len_q    <= len_n;
            timer    <= timer_n;
            run      <= (state_n == S_ISSUE);
            busy     <= (state_n == S_ISSUE) || (state_n == S_WAIT) || (state_n == S_FINISH);
            seq_done <= (state_n == S_FINISH);
            error    <= (state_n == S_ERROR);
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer with TIMEOUT=8; one task per scenario.
module tb_instruction_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_we = 1'b0;
    logic [3:0]  load_addr = '0;
    logic [15:0] load_data = '0;
    logic [4:0]  prog_len = '0;
    logic        start = 1'b0;
    logic        done = 1'b0;
    logic [15:0] DIN;
    logic        run, busy, seq_done, error;
    logic [3:0]  pc;

    int checks = 0;
    int fails  = 0;

    instruction_sequencer #(.DEPTH(16), .ADDR_W(4), .TIMEOUT(8)) dut (
        .clk_50MHz(clk), .reset(reset), .load_we(load_we), .load_addr(load_addr),
        .load_data(load_data), .prog_len(prog_len), .start(start), .done(done),
        .DIN(DIN), .run(run), .busy(busy), .seq_done(seq_done), .error(error), .pc(pc)
    );

    always #5 clk = ~clk;

    // Advance past one rising edge; outputs then reflect that edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [15:0] d);
        load_we = 1'b1; load_addr = a; load_data = d;
        tick();
        load_we = 1'b0;
    endtask

    task automatic kick(input logic [4:0] len);
        prog_len = len; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called in the ISSUE cycle; done is sampled on the third edge after it.
    task automatic ack3();
        tick(); tick();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        checks++;
        if ({DIN, run, busy, seq_done, error, pc} !== 24'h0) begin
            fails++;
            $display("FAIL reset_values got DIN=%h run=%b busy=%b sd=%b err=%b pc=%0d want all 0",
                     DIN, run, busy, seq_done, error, pc);
        end
    endtask

    task automatic test_three_instr();
        logic [15:0] words [3];
        words[0] = 16'h11FF; words[1] = 16'h13FE; words[2] = 16'h4001;
        load(4'd0, words[0]); load(4'd1, words[1]); load(4'd2, words[2]);
        kick(5'd3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (run !== 1'b1 || DIN !== words[i] || pc !== 4'(i) || busy !== 1'b1) begin
                fails++;
                $display("FAIL three_issue%0d got run=%b DIN=%h pc=%0d busy=%b want run=1 DIN=%h pc=%0d busy=1",
                         i, run, DIN, pc, busy, words[i], i);
            end
            tick();
            checks++;
            if (run !== 1'b0 || DIN !== words[i]) begin
                fails++;
                $display("FAIL three_wait%0d got run=%b DIN=%h want run=0 DIN=%h", i, run, DIN, words[i]);
            end
            tick();
            done = 1'b1;
            tick();
            done = 1'b0;
        end
        checks++;
        if (seq_done !== 1'b1 || pc !== 4'd2 || error !== 1'b0 || busy !== 1'b1 || run !== 1'b0) begin
            fails++;
            $display("FAIL three_finish got sd=%b pc=%0d err=%b busy=%b run=%b want 1 2 0 1 0",
                     seq_done, pc, error, busy, run);
        end
        tick();
        checks++;
        if (seq_done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL three_idle got sd=%b busy=%b want 0 0", seq_done, busy);
        end
    endtask

    task automatic test_zero_len();
        kick(5'd0);
        checks++;
        if (seq_done !== 1'b1 || busy !== 1'b1 || run !== 1'b0) begin
            fails++;
            $display("FAIL zero_finish got sd=%b busy=%b run=%b want 1 1 0", seq_done, busy, run);
        end
        tick();
        checks++;
        if (seq_done !== 1'b0 || busy !== 1'b0 || run !== 1'b0) begin
            fails++;
            $display("FAIL zero_idle got sd=%b busy=%b run=%b want 0 0 0", seq_done, busy, run);
        end
    endtask

    task automatic test_timeout();
        int runs = 0;
        kick(5'd2);
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (run === 1'b1) runs++;
        end
        checks++;
        if (error !== 1'b0 || busy !== 1'b1 || runs != 0) begin
            fails++;
            $display("FAIL timeout_r7 got err=%b busy=%b extra_runs=%0d want 0 1 0", error, busy, runs);
        end
        tick();
        checks++;
        if (error !== 1'b1 || busy !== 1'b0 || run !== 1'b0 || pc !== 4'd0 || DIN !== 16'h11FF) begin
            fails++;
            $display("FAIL timeout_r8 got err=%b busy=%b run=%b pc=%0d DIN=%h want 1 0 0 0 11ff",
                     error, busy, run, pc, DIN);
        end
        tick(); tick();
        checks++;
        if (error !== 1'b1 || DIN !== 16'h11FF) begin
            fails++;
            $display("FAIL timeout_hold got err=%b DIN=%h want 1 11ff", error, DIN);
        end
        kick(5'd2);
        checks++;
        if (error !== 1'b0 || run !== 1'b1 || DIN !== 16'h11FF || pc !== 4'd0) begin
            fails++;
            $display("FAIL timeout_restart got err=%b run=%b DIN=%h pc=%0d want 0 1 11ff 0",
                     error, run, DIN, pc);
        end
        for (int k = 0; k < 8; k++) tick();
        checks++;
        if (error !== 1'b1) begin
            fails++;
            $display("FAIL timeout_again got err=%b want 1", error);
        end
    endtask

    task automatic test_busy_writes();
        kick(5'd3);
        tick();
        load_we = 1'b1; load_addr = 4'd1; load_data = 16'hFFFF;
        start = 1'b1; prog_len = 5'd1;
        tick();
        load_we = 1'b0; start = 1'b0;
        checks++;
        if (busy !== 1'b1 || run !== 1'b0 || pc !== 4'd0 || error !== 1'b0) begin
            fails++;
            $display("FAIL busy_ignore got busy=%b run=%b pc=%0d err=%b want 1 0 0 0", busy, run, pc, error);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (run !== 1'b1 || DIN !== 16'h13FE || pc !== 4'd1) begin
            fails++;
            $display("FAIL busy_mem1 got run=%b DIN=%h pc=%0d want 1 13fe 1", run, DIN, pc);
        end
        ack3();
        checks++;
        if (run !== 1'b1 || DIN !== 16'h4001 || pc !== 4'd2) begin
            fails++;
            $display("FAIL busy_mem2 got run=%b DIN=%h pc=%0d want 1 4001 2", run, DIN, pc);
        end
        ack3();
        checks++;
        if (seq_done !== 1'b1 || pc !== 4'd2) begin
            fails++;
            $display("FAIL busy_finish got sd=%b pc=%0d want 1 2", seq_done, pc);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int runs = 0;
        load(4'd3, 16'h2222);
        kick(5'd4);
        ack3();
        checks++;
        if (run !== 1'b1 || pc !== 4'd1) begin
            fails++;
            $display("FAIL mid_second got run=%b pc=%0d want 1 1", run, pc);
        end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({DIN, run, busy, seq_done, error, pc} !== 24'h0) begin
            fails++;
            $display("FAIL mid_reset got DIN=%h run=%b busy=%b sd=%b err=%b pc=%0d want all 0",
                     DIN, run, busy, seq_done, error, pc);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            if (run === 1'b1 || busy === 1'b1) runs++;
        end
        checks++;
        if (runs != 0) begin
            fails++;
            $display("FAIL mid_quiet got active_cycles=%0d want 0", runs);
        end
        kick(5'd4);
        checks++;
        if (run !== 1'b1 || DIN !== 16'h11FF || pc !== 4'd0) begin
            fails++;
            $display("FAIL mid_restart got run=%b DIN=%h pc=%0d want 1 11ff 0", run, DIN, pc);
        end
        ack3(); ack3(); ack3();
        checks++;
        if (run !== 1'b1 || DIN !== 16'h2222 || pc !== 4'd3) begin
            fails++;
            $display("FAIL mid_mem3 got run=%b DIN=%h pc=%0d want 1 2222 3", run, DIN, pc);
        end
        ack3();
        checks++;
        if (seq_done !== 1'b1) begin
            fails++;
            $display("FAIL mid_finish got sd=%b want 1", seq_done);
        end
        tick();
    endtask

    task automatic test_done_edges();
        kick(5'd2);
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (run !== 1'b0 || busy !== 1'b1 || pc !== 4'd0) begin
            fails++;
            $display("FAIL edge_issue_done got run=%b busy=%b pc=%0d want 0 1 0", run, busy, pc);
        end
        for (int k = 0; k < 6; k++) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (error !== 1'b0 || run !== 1'b1 || pc !== 4'd1 || DIN !== 16'h13FE) begin
            fails++;
            $display("FAIL edge_coincide got err=%b run=%b pc=%0d DIN=%h want 0 1 1 13fe",
                     error, run, pc, DIN);
        end
        for (int k = 0; k < 8; k++) tick();
        checks++;
        if (error !== 1'b1 || pc !== 4'd1) begin
            fails++;
            $display("FAIL edge_timeout2 got err=%b pc=%0d want 1 1", error, pc);
        end
        // write to address 0 in the same cycle as the accepted start
        load_we = 1'b1; load_addr = 4'd0; load_data = 16'hAAAA;
        prog_len = 5'd1; start = 1'b1;
        tick();
        load_we = 1'b0; start = 1'b0;
        checks++;
        if (run !== 1'b1 || DIN !== 16'h11FF || error !== 1'b0) begin
            fails++;
            $display("FAIL edge_prewrite got run=%b DIN=%h err=%b want 1 11ff 0", run, DIN, error);
        end
        ack3();
        tick();
        kick(5'd1);
        checks++;
        if (run !== 1'b1 || DIN !== 16'hAAAA) begin
            fails++;
            $display("FAIL edge_postwrite got run=%b DIN=%h want 1 aaaa", run, DIN);
        end
        ack3();
        tick();
    endtask

    initial begin
        test_reset();
        test_three_instr();
        test_zero_len();
        test_timeout();
        test_busy_writes();
        test_reset_mid();
        test_done_edges();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Upstream feeder for `simple_processor`. It holds a small program of 16-bit instruction words, loaded through a write port. On `start` it issues each word to the processor over the `DIN`/`run` pair, then waits for the processor's `done` before issuing the next word. It reports completion, and reports a timeout error if the processor stops responding.

## Interface
- `DEPTH`, 16: program memory depth in words.
- `ADDR_W`, 4: address width, equal to log2(`DEPTH`).
- `TIMEOUT`, 255: maximum cycles spent in WAIT before the error is raised (must be ≥ 2).
- `clk_50MHz` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `load_we` in 1: program memory write strobe.
- `load_addr` in `ADDR_W`: program memory write address.
- `load_data` in 16: instruction word to write.
- `prog_len` in `ADDR_W`+1: number of instructions to run, 0..`DEPTH`; sampled on `start`.
- `start` in 1: begin a sequence; honoured only in IDLE or ERROR.
- `done` in 1: from the processor; instruction complete.
- `DIN` out 16: instruction word to the processor.
- `run` out 1: one-cycle issue strobe to the processor.
- `busy` out 1: high in every state except IDLE and ERROR.
- `seq_done` out 1: one-cycle pulse when all instructions have completed.
- `error` out 1: timeout flag; stays high until `reset` or an accepted `start`.
- `pc` out `ADDR_W`: index of the current instruction.

## Operation
- **State machine:** IDLE, ISSUE, WAIT, FINISH, ERROR.
- **IDLE**
  - `start`=1 and `prog_len`≠0: latch `prog_len` into `len_q`, set `pc`=0, load `DIN`←mem[0], go to ISSUE.
  - `start`=1 and `prog_len`=0: go to FINISH.
- **ISSUE** (always exactly one cycle): `run`=1, clear the timer, go to WAIT. `done` sampled in this cycle is ignored.
- **WAIT**: `run`=0, `DIN` held stable, timer increments every cycle.
  - `done`=1 and `pc`=`len_q`−1: go to FINISH.
  - `done`=1 otherwise: `pc`←`pc`+1, `DIN`←mem[`pc`+1], go to ISSUE.
  - Timer reaches `TIMEOUT`−1 with `done`=0: go to ERROR, set `error`=1.
  - If `done` and the timeout coincide in the same cycle, `done` wins.
- **FINISH**: `seq_done`=1 for one cycle, then go to IDLE.
- **ERROR**: `busy`=0, `pc` and `DIN` frozen. An accepted `start` clears `error` and behaves exactly as a `start` in IDLE.
- **Program memory**
  - Read is combinational from the registered `pc` path.
  - Write happens on an edge with `load_we`=1, and only when `busy`=0. Writes while `busy`=1 are dropped.
  - The memory is not cleared by `reset`.
  - A write in the same cycle as an accepted `start` completes first, but `DIN` loads the pre-write contents of mem[0].
- **Ignored and mid-operation events**
  - `start` while `busy`=1 is ignored.
  - `done` in IDLE, FINISH or ERROR is ignored.
  - `reset` mid-sequence aborts on the next edge: no further `run` is issued and the block returns to IDLE.
- **Arithmetic**: `pc` never wraps, because `len_q`≤`DEPTH`. For `prog_len`>`DEPTH`, `len_q` saturates to `DEPTH`.

## Timing
- **Reset values**: state=IDLE, `DIN`=16'h0000, `run`=0, `busy`=0, `seq_done`=0, `error`=0, `pc`=0, timer=0.
- **Start latency**: with `start` sampled at edge T, `run`=1 and `DIN`=mem[0] hold during cycle T+1.
- **Issue-to-issue**: with `done` sampled high at edge W, the next `run` is high during cycle W+1. The minimum spacing between `run` pulses is 2 cycles.
- **Completion**: the final `done` at edge W gives `seq_done` high during cycle W+1; `busy` falls at cycle W+2.
- **Timeout**: `run` at cycle R with no `done` gives `error` and `busy`=0 from cycle R+`TIMEOUT`.
- **Registered outputs**: all outputs are registered; no output depends combinationally on inputs.
- **`DIN` stability**: `DIN` changes only on the edge that enters ISSUE.

## Test plan
- **Three-instruction program**: load 0x11FF, 0x13FE, 0x4001 into addresses 0..2; `prog_len`=3; `start`. Ack each `run` with `done` 3 cycles later. Required: three `run` pulses carrying those words in order, then `seq_done` once, `pc`=2, `error`=0.
- **Zero-length start**: `prog_len`=0, `start`. Required: no `run`; `seq_done` in the cycle after `start`; `busy` high for exactly 1 cycle.
- **Timeout**: `TIMEOUT`=8, `prog_len`=2, never assert `done`. Required: one `run`, then `error`=1 and `busy`=0 at 8 cycles after that `run`. A subsequent `start` clears `error` and reissues mem[0].
- **Writes and starts while busy**: during WAIT, pulse `load_we` to address 1 with 0xFFFF and pulse `start`. Required: mem[1] keeps its original value; the sequence continues unchanged.
- **Reset mid-sequence**: assert `reset` for 1 cycle during WAIT of instruction 2 of 4. Required: all outputs at their reset values on the next cycle; no further `run`; memory contents intact; a re-`start` runs from address 0.
- **`done` edge cases**: assert `done` during ISSUE, and again in the same cycle the timer hits `TIMEOUT`−1. Required: the ISSUE-cycle `done` is ignored (still WAIT); the coincident `done` advances `pc` and no error is raised.
